fpga_reset_sequencer: RTL

- Clock-and-reset controller for the FPGA top level. Sits between the board reset button, the clock-generation lock signal and the SoC's active-low reset and JTAG TRST pads.
- Debounces and synchronizes the button reset, then waits for a stable clock lock.
- Releases JTAG TRST first and SoC reset last, on a fixed, counted schedule.
- Reacts to clock-lock loss and to software reset requests, and records the cause of the last reset.

---
 rtl/fpga_reset_sequencer_if.sv | 31 +++
 rtl/fpga_reset_sequencer.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/fpga_reset_sequencer_if.sv
// Lock, software-request and reset-output bundle of the reset sequencer.
// Sequencer side is the slave; the board/SoC wrapper side is the master.
interface fpga_reset_sequencer_if;
  logic       mmcm_locked_i;
  logic       sw_reset_req_i;
  logic       soc_rst_no;
  logic       jtag_trst_no;
  logic       ready_o;
  logic [2:0] rst_state_o;
  logic [1:0] rst_cause_o;

  modport master (
    output mmcm_locked_i,
    output sw_reset_req_i,
    input  soc_rst_no,
    input  jtag_trst_no,
    input  ready_o,
    input  rst_state_o,
    input  rst_cause_o
  );

  modport slave (
    input  mmcm_locked_i,
    input  sw_reset_req_i,
    output soc_rst_no,
    output jtag_trst_no,
    output ready_o,
    output rst_state_o,
    output rst_cause_o
  );
endinterface

// File: rtl/fpga_reset_sequencer.sv
// Board reset sequencer: debounce, wait for stable lock, release TRST then SoC reset.
// Outputs are registered with the state (1 cycle after the deciding sample); no backpressure.
module fpga_reset_sequencer #(
  parameter int DEBOUNCE_CYCLES  = 1000,
  parameter int LOCK_WAIT_CYCLES = 256,
  parameter int SOC_HOLD_CYCLES  = 64,
  parameter int CNT_WIDTH        = 16
) (
  input  logic                   ref_clk,
  input  logic                   pad_reset,
  fpga_reset_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    DEBOUNCE    = 3'd0,
    WAIT_LOCK   = 3'd1,
    LOCK_STABLE = 3'd2,
    HOLD_SOC    = 3'd3,
    RUN         = 3'd4
  } state_t;

  localparam logic [CNT_WIDTH-1:0] DEB_LOAD  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] LOCK_LOAD = CNT_WIDTH'(LOCK_WAIT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] HOLD_LOAD = CNT_WIDTH'(SOC_HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  localparam logic [1:0] CAUSE_PAD  = 2'd0;
  localparam logic [1:0] CAUSE_LOCK = 2'd1;
  localparam logic [1:0] CAUSE_SW   = 2'd2;

  logic                 rst_meta;
  logic                 rst_int;
  logic                 lock_meta;
  logic                 lock_s;
  logic                 sw_prev;
  logic                 sw_rise;
  state_t               state;
  state_t               state_nxt;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_nxt;
  logic [1:0]           cause;
  logic [1:0]           cause_nxt;
  logic                 soc_rst_n;
  logic                 trst_n;
  logic                 ready;

  // Assert immediately on the button, release only after two clean clock edges.
  always_ff @(posedge ref_clk or posedge pad_reset) begin
    if (pad_reset) begin
      rst_meta <= 1'b1;
      rst_int  <= 1'b1;
    end else begin
      rst_meta <= 1'b0;
      rst_int  <= rst_meta;
    end
  end

  always_ff @(posedge ref_clk or posedge rst_int) begin
    if (rst_int) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= bus.mmcm_locked_i;
      lock_s    <= lock_meta;
    end
  end

  assign sw_rise = bus.sw_reset_req_i & ~sw_prev;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cause_nxt = cause;
    case (state)
      DEBOUNCE: begin
        if (cnt == '0) state_nxt = WAIT_LOCK;
        else           cnt_nxt   = cnt - CNT_ONE;
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt = LOCK_STABLE;
          cnt_nxt   = LOCK_LOAD;
        end
      end
      LOCK_STABLE: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
        end else if (cnt == '0) begin
          state_nxt = HOLD_SOC;
          cnt_nxt   = HOLD_LOAD;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      HOLD_SOC: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          cause_nxt = CAUSE_LOCK;
        end else if (cnt == '0) begin
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      RUN: begin
        // Lock loss outranks a software request arriving on the same cycle.
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          cause_nxt = CAUSE_LOCK;
        end else if (sw_rise) begin
          state_nxt = HOLD_SOC;
          cnt_nxt   = HOLD_LOAD;
          cause_nxt = CAUSE_SW;
        end
      end
      default: begin
        state_nxt = DEBOUNCE;
        cnt_nxt   = DEB_LOAD;
      end
    endcase
  end

  always_ff @(posedge ref_clk or posedge rst_int) begin
    if (rst_int) begin
      state     <= DEBOUNCE;
      cnt       <= DEB_LOAD;
      cause     <= CAUSE_PAD;
      sw_prev   <= 1'b0;
      trst_n    <= 1'b0;
      soc_rst_n <= 1'b0;
      ready     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      cause     <= cause_nxt;
      sw_prev   <= bus.sw_reset_req_i;
      trst_n    <= (state_nxt == HOLD_SOC) || (state_nxt == RUN);
      soc_rst_n <= (state_nxt == RUN);
      ready     <= (state_nxt == RUN);
    end
  end

  assign bus.soc_rst_no   = soc_rst_n;
  assign bus.jtag_trst_no = trst_n;
  assign bus.ready_o      = ready;
  assign bus.rst_state_o  = state;
  assign bus.rst_cause_o  = cause;

endmodule
